gf_asm: RTL and testbench

//   Registered half-word adder for the Galois_Field arithmetic datapath.
//   - Splits the SIZE-bit input word into an upper half and a lower half.
//   - Adds the two halves as unsigned integers.
//   - Returns the full (WIDTH+1)-bit sum, carry included, one clock later.
//   - Serves as the add stage in front of later GF reduction/multiply stages.

---
 rtl/gf_pkg.sv | 10 +
 rtl/gf_full_adder.sv | 18 +
 rtl/gf_asm.sv | 52 +++++
 tb/tb_gf_asm.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared constants and helpers for the Galois-field arithmetic datapath.
package gf_pkg;

    localparam int GF_SIZE = 8;

    function automatic int half_w(input int size);
        return size / 2;
    endfunction

endpackage

// File: rtl/gf_full_adder.sv
// One-bit full adder used as a link of the half-word ripple-carry chain.
module gf_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    always_comb begin
        p  = a ^ b;
        s  = p ^ ci;
        co = (a & b) | (ci & p);
    end

endmodule

// File: rtl/gf_asm.sv
// Registered half-word adder: out <= in[SIZE-1:WIDTH] + in[WIDTH-1:0], carry kept.
// No handshake: in is sampled on every rising edge and out is valid one edge later.
module gf_asm
    import gf_pkg::*;
#(
    parameter  int SIZE  = GF_SIZE,
    localparam int WIDTH = half_w(SIZE),
    localparam int OUT   = WIDTH + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] in,
    output logic [OUT-1:0]  out
);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_bits;
    logic [WIDTH:0]   carry;
    logic [OUT-1:0]   out_d;
    logic [OUT-1:0]   out_q;

    assign op_a     = in[SIZE-1:WIDTH];
    assign op_b     = in[WIDTH-1:0];
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        gf_full_adder u_fa (
            .a  (op_a[i]),
            .b  (op_b[i]),
            .ci (carry[i]),
            .s  (sum_bits[i]),
            .co (carry[i+1])
        );
    end

    // The MSB carry-out becomes the top output bit, so the sum can never overflow.
    always_comb begin
        out_d = {carry[WIDTH], sum_bits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_gf_asm.sv
// Bench for gf_asm: default SIZE=8 instance plus a SIZE=4 instance on shared clock/reset.
module tb_gf_asm;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic [7:0] din;
    logic [4:0] dout;
    logic [3:0] din4;
    logic [2:0] dout4;
    logic       cmp_en;

    int total;
    int bad;
    int exp8;
    int exp4;

    gf_asm u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (din),
        .out   (dout)
    );

    gf_asm #(.SIZE(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (din4),
        .out   (dout4)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: upper half plus lower half as plain integers, zero in reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp8 = 0;
            exp4 = 0;
        end else begin
            exp8 = int'(din) / 16 + int'(din) % 16;
            exp4 = int'(din4) / 4 + int'(din4) % 4;
        end
    end

    // Compare process, on the falling edge away from the sampling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("stream8", int'(dout), exp8);
            check("stream4", int'(dout4), exp4);
        end
    end

    // Driver: change inputs between edges, return just after the edge that loads them.
    task automatic apply(input logic [7:0] v8, input logic [3:0] v4);
        @(posedge clk);
        #2;
        din  = v8;
        din4 = v4;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cmp_en  = 1'b0;
        clk_run = 1'b0;
        rst_n   = 1'b1;
        din     = 8'hFF;
        din4    = 4'hF;

        // Reset with the clock stopped: clear must be asynchronous.
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_async", int'(dout), 0);
        check("reset_async4", int'(dout4), 0);

        clk_run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("reset_hold", int'(dout), 0);
        end
        cmp_en = 1'b1;
        #1;
        rst_n = 1'b1;

        // Directed vectors with hand-computed results
        apply(8'b0101_0001, 4'b1001);
        check("directed_5p1", int'(dout), 6);
        check("size4_1001", int'(dout4), 3);
        apply(8'b1111_1111, 4'b1111);
        check("max", int'(dout), 30);
        check("size4_max", int'(dout4), 6);
        apply(8'b1111_0001, 4'b1101);
        check("carry", int'(dout), 16);
        check("size4_carry", int'(dout4), 4);
        apply(8'h00, 4'h0);
        check("zero", int'(dout), 0);
        check("size4_zero", int'(dout4), 0);
        apply(8'h0F, 4'h3);
        check("b_only", int'(dout), 15);
        check("size4_b_only", int'(dout4), 3);

        // Mid-stream reset pulse between edges
        apply(8'b0101_0001, 4'b1001);
        check("pre_reset", int'(dout), 6);
        #1;
        din   = 8'h23;
        din4  = 4'h6;
        rst_n = 1'b0;
        #1;
        check("mid_reset_clear", int'(dout), 0);
        check("mid_reset_clear4", int'(dout4), 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset", int'(dout), 5);
        check("post_reset4", int'(dout4), 3);

        // Exhaustive back-to-back stream, one input per cycle
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #2;
            din  = 8'(i);
            din4 = 4'(i);
        end
        @(posedge clk);
        #1;
        check("exh_last", int'(dout), 30);
        check("exh_last4", int'(dout4), 6);
        @(negedge clk);
        #1;
        cmp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
